// File: rtl/tawas_load_wb.sv
// tawas_load_wb: in-order return queue for bus load data, merged into the
// register-file writeback slot whenever the pipeline leaves it compatible.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   rd_vld / rd_rdy                  load-return handshake
//   rd_thread, rd_reg, rd_data       returning beat {thread, reg, data}
//   pipe_wb_en, pipe_wb_thread       pipeline ownership of the writeback slot
//   pipe_au_en/reg, pipe_ptr_en/reg  pipeline register writes this cycle
//   wb_thread                        register-file writeback thread
//   wb_store_en/reg/data             load-data register write
//   pend_mask                        per-thread "has queued return" flags
//   pend_cnt                         occupied entries, 0..DEPTH
module tawas_load_wb #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rd_vld,
  output logic                       rd_rdy,
  input  logic [4:0]                 rd_thread,
  input  logic [2:0]                 rd_reg,
  input  logic [31:0]                rd_data,
  input  logic                       pipe_wb_en,
  input  logic [4:0]                 pipe_wb_thread,
  input  logic                       pipe_au_en,
  input  logic [2:0]                 pipe_au_reg,
  input  logic                       pipe_ptr_en,
  input  logic [2:0]                 pipe_ptr_reg,
  output logic [4:0]                 wb_thread,
  output logic                       wb_store_en,
  output logic [2:0]                 wb_store_reg,
  output logic [31:0]                wb_store_data,
  output logic [31:0]                pend_mask,
  output logic [$clog2(DEPTH):0]     pend_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Entry storage is deliberately not reset; all outputs are gated by cnt_q.
  logic [4:0]      thread_q [DEPTH];
  logic [2:0]      reg_q    [DEPTH];
  logic [31:0]     data_q   [DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     mask_q, mask_d;
  logic            rdy_q, rdy_d;

  logic            push, pop, head_ok;
  logic [4:0]      head_thread;
  logic [2:0]      head_reg;
  logic [31:0]     head_data;

  assign head_thread = thread_q[rd_ptr_q];
  assign head_reg    = reg_q[rd_ptr_q];
  assign head_data   = data_q[rd_ptr_q];

  always_comb begin
    head_ok = (cnt_q != '0)
            && (!pipe_wb_en || (pipe_wb_thread == head_thread))
            && !(pipe_au_en && (pipe_au_reg == head_reg))
            && !(pipe_ptr_en && (pipe_ptr_reg == head_reg));
  end

  // rd_rdy comes straight from a flop, so no input reaches it combinationally.
  assign rd_rdy = rdy_q;
  assign push   = rd_vld && rdy_q;
  assign pop    = head_ok;

  always_comb begin
    wb_store_en   = head_ok;
    wb_store_reg  = head_ok ? head_reg  : 3'd0;
    wb_store_data = head_ok ? head_data : 32'd0;
    if (pipe_wb_en) begin
      wb_thread = pipe_wb_thread;
    end else if (head_ok) begin
      wb_thread = head_thread;
    end else begin
      wb_thread = 5'd0;
    end
  end

  // Next-state pointers/count; pointer wrap is free because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
    rdy_d    = (cnt_d < CntW'(DEPTH));
  end

  // pend_mask is rebuilt from the post-edge occupancy so it is exact after every edge.
  always_comb begin
    mask_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PtrW-1:0] off;
      logic [4:0]      thr;
      off = PtrW'(i) - rd_ptr_d;
      thr = (push && (wr_ptr_q == PtrW'(i))) ? rd_thread : thread_q[i];
      if (CntW'(off) < cnt_d) begin
        mask_d[thr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      thread_q[wr_ptr_q] <= rd_thread;
      reg_q[wr_ptr_q]    <= rd_reg;
      data_q[wr_ptr_q]   <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      rdy_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      rdy_q    <= rdy_d;
    end
  end

  assign pend_mask = mask_q;
  assign pend_cnt  = cnt_q;

endmodule
